// File: rtl/cg_mem_arb_pkg.sv
// Shared types and helpers for the two-master memory arbiter.
//   master_id_t  : identifies one of the NUM_MASTERS requesters
//   rr_next()    : round-robin pointer advance after a grant
//   rr_pick()    : grant selection from a request vector and priority pointer
//   id_onehot()  : one-hot per-master vector for an id
package cg_mem_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  typedef logic master_id_t;

  // Priority moves to the master that was not just served.
  function automatic master_id_t rr_next(input master_id_t granted);
    return master_id_t'(~granted);
  endfunction

  // Lone requester wins; on contention the pointer decides.
  function automatic master_id_t rr_pick(input logic [NUM_MASTERS-1:0] req,
                                         input master_id_t ptr);
    if (req == 2'b11) return ptr;
    return master_id_t'(req[1]);
  endfunction

  function automatic logic [NUM_MASTERS-1:0] id_onehot(input master_id_t id);
    return NUM_MASTERS'(1) << id;
  endfunction

endpackage

// File: rtl/cg_memory_arbiter_if.sv
// Bus bundle between two masters, the arbiter and the single memory port.
//   s_* : per-master read request / read response / write channels
//   m_* : memory-side read request / read response / write channels
// Modports:
//   slave  : the arbiter's view (serves the masters, drives the memory port)
//   master : the environment's view (masters plus memory)
interface cg_memory_arbiter_if
  import cg_mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [NUM_MASTERS-1:0]                 s_raddr_valid;
  logic [NUM_MASTERS-1:0]                 s_raddr_ready;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_raddr;
  logic [NUM_MASTERS-1:0]                 s_rdata_valid;
  logic [NUM_MASTERS-1:0]                 s_rdata_ready;
  logic [DATA_WIDTH-1:0]                  s_rdata;
  logic [NUM_MASTERS-1:0]                 s_wen;
  logic [NUM_MASTERS-1:0]                 s_wdata_valid;
  logic [NUM_MASTERS-1:0]                 s_wdata_ready;
  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_waddr;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_wdata;

  logic                  m_raddr_valid;
  logic                  m_raddr_ready;
  logic [ADDR_WIDTH-1:0] m_raddr;
  logic                  m_rdata_valid;
  logic                  m_rdata_ready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_wen;
  logic                  m_wdata_valid;
  logic                  m_wdata_ready;
  logic [ADDR_WIDTH-1:0] m_waddr;
  logic [DATA_WIDTH-1:0] m_wdata;

  modport slave (
    input  s_raddr_valid, s_raddr, s_rdata_ready, s_wen, s_wdata_valid, s_waddr, s_wdata,
           m_raddr_ready, m_rdata_valid, m_rdata, m_wdata_ready,
    output s_raddr_ready, s_rdata_valid, s_rdata, s_wdata_ready,
           m_raddr_valid, m_raddr, m_rdata_ready, m_wen, m_wdata_valid, m_waddr, m_wdata
  );

  modport master (
    output s_raddr_valid, s_raddr, s_rdata_ready, s_wen, s_wdata_valid, s_waddr, s_wdata,
           m_raddr_ready, m_rdata_valid, m_rdata, m_wdata_ready,
    input  s_raddr_ready, s_rdata_valid, s_rdata, s_wdata_ready,
           m_raddr_valid, m_raddr, m_rdata_ready, m_wen, m_wdata_valid, m_waddr, m_wdata
  );

endinterface

// File: rtl/cg_id_fifo.sv
// Synchronous FIFO of master ids for reads in flight, oldest at head.
//   i_clk, i_rst_n : clock, async active-low reset (clears pointers)
//   push, push_id  : enqueue an id (ignored when full)
//   pop            : dequeue the head (ignored when empty)
//   head           : id of the oldest outstanding read
//   full, empty    : occupancy flags from the current pointers only
module cg_id_fifo
  import cg_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       push,
  input  master_id_t push_id,
  input  logic       pop,
  output master_id_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  master_id_t    slot_q [DEPTH];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = slot_q[rd_q[AW-1:0]];

  // Pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full)  wr_q <= wr_q + PW'(1);
      if (pop  && !empty) rd_q <= rd_q + PW'(1);
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge i_clk) begin
    if (push && !full) slot_q[wr_q[AW-1:0]] <= push_id;
  end

endmodule

// File: rtl/cg_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single memory port.
// Read and write requests are granted combinationally (no added latency);
// read responses, which the memory returns in issue order, are routed back
// to the issuing master using a FIFO of outstanding master ids.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset; forces every ready/valid output low
//   bus     : slave view of the master/memory bundle
module cg_memory_arbiter
  import cg_mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned OUTSTANDING = 4
) (
  input logic                i_clk,
  input logic                i_rst_n,
  cg_memory_arbiter_if.slave bus
);

  master_id_t rd_ptr;
  master_id_t wr_ptr;
  master_id_t rd_grant;
  master_id_t wr_grant;
  master_id_t head_id;
  logic       fifo_full;
  logic       fifo_empty;
  logic       rd_issue_c;
  logic       rd_hs;
  logic       rsp_ok_c;
  logic       rsp_hs;
  logic       wr_req_any;
  logic       wr_hs;

  logic [NUM_MASTERS-1:0] wr_req;
  logic [ADDR_WIDTH-1:0]  rd_addr_c;
  logic [DATA_WIDTH-1:0]  rsp_data_c;

  // Read request arbitration; a full ID FIFO blocks issue.
  assign rd_grant          = rr_pick(bus.s_raddr_valid, rd_ptr);
  assign rd_addr_c         = bus.s_raddr[rd_grant];
  assign bus.m_raddr_valid = i_rst_n & (|bus.s_raddr_valid) & ~fifo_full;
  assign bus.m_raddr       = rd_addr_c;
  assign rd_issue_c        = bus.m_raddr_valid & bus.m_raddr_ready;
  assign bus.s_raddr_ready = id_onehot(rd_grant) & {NUM_MASTERS{rd_issue_c}};
  assign rd_hs             = rd_issue_c;

  // Response routing to the master at the FIFO head.
  assign rsp_ok_c          = i_rst_n & ~fifo_empty;
  assign bus.s_rdata_valid = id_onehot(head_id) & {NUM_MASTERS{rsp_ok_c & bus.m_rdata_valid}};
  assign bus.m_rdata_ready = rsp_ok_c & bus.s_rdata_ready[head_id];
  assign rsp_data_c        = bus.m_rdata;
  assign bus.s_rdata       = rsp_data_c;
  assign rsp_hs            = bus.m_rdata_valid & bus.m_rdata_ready;

  // Write arbitration, independent of the read channel.
  assign wr_req            = bus.s_wen & bus.s_wdata_valid;
  assign wr_req_any        = i_rst_n & (|wr_req);
  assign wr_grant          = rr_pick(wr_req, wr_ptr);
  assign bus.m_wen         = wr_req_any;
  assign bus.m_wdata_valid = wr_req_any;
  assign bus.m_waddr       = bus.s_waddr[wr_grant];
  assign bus.m_wdata       = bus.s_wdata[wr_grant];
  assign wr_hs             = wr_req_any & bus.m_wdata_ready;
  assign bus.s_wdata_ready = id_onehot(wr_grant) & {NUM_MASTERS{wr_hs}};

  // Priority pointers only move on a handshake so a stalled grant stays put.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (rd_hs) rd_ptr <= rr_next(rd_grant);
      if (wr_hs) wr_ptr <= rr_next(wr_grant);
    end
  end

  cg_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (rd_hs),
    .push_id (rd_grant),
    .pop     (rsp_hs),
    .head    (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A response with nothing outstanding is a memory protocol violation; it is dropped.
  a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                    !(bus.m_rdata_valid && fifo_empty));

endmodule

// File: tb/tb_cg_memory_arbiter.sv
// Randomized self-checking bench for cg_memory_arbiter. Masters and the
// memory are modelled here; the expected arbiter outputs come from a
// transaction-level model (queue of outstanding reads, per-master expected
// data queues, a behavioural memory array and two priority bits).
module tb_cg_memory_arbiter;
  import cg_mem_arb_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned OUT = 4;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  always #5 i_clk = ~i_clk;

  cg_memory_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cg_memory_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .OUTSTANDING (OUT)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Stimulus knobs (percent probabilities)
  int unsigned p_rd [2];
  int unsigned p_wr, p_rrdy, p_mrrdy, p_mwrdy, lat_max;

  // Master state: a request is held until accepted
  bit          rd_pend [2];
  logic [31:0] rd_addr [2];
  bit          wr_pend [2];
  logic [31:0] wr_addr [2];
  logic [31:0] wr_dat  [2];

  // Memory model
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rsp_data [$];
  longint      rsp_time [$];
  longint      cyc = 0;

  // Reference model
  bit          rd_pri = 1'b0;
  bit          wr_pri = 1'b0;
  bit          idq [$];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];

  // Per-cycle results
  bit          rd_hs, rsp_hs, wr_hs, rd_g, rsp_id, wr_g;
  logic [31:0] rsp_val;
  logic [1:0]  obs_srr, obs_srv, obs_swr;
  logic [31:0] obs_maddr, obs_rdata, obs_waddr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic drive();
    int unsigned r;
    for (int m = 0; m < 2; m++) begin
      if (!rd_pend[m] && $urandom_range(99) < p_rd[m]) begin
        rd_pend[m] = 1'b1;
        rd_addr[m] = 32'($urandom_range(31)) << 2;
      end
      if (!wr_pend[m] && $urandom_range(99) < p_wr) begin
        wr_pend[m] = 1'b1;
        wr_addr[m] = 32'($urandom_range(31)) << 2;
        wr_dat[m]  = $urandom;
      end
      bus.s_raddr_valid[m] = rd_pend[m];
      bus.s_raddr[m]       = rd_pend[m] ? rd_addr[m] : $urandom;
      bus.s_rdata_ready[m] = ($urandom_range(99) < p_rrdy);
      if (wr_pend[m]) begin
        bus.s_wen[m]         = 1'b1;
        bus.s_wdata_valid[m] = 1'b1;
      end else begin
        r = $urandom_range(2);
        bus.s_wen[m]         = (r == 1);
        bus.s_wdata_valid[m] = (r == 2);
      end
      bus.s_waddr[m] = wr_addr[m];
      bus.s_wdata[m] = wr_dat[m];
    end
    bus.m_raddr_ready = ($urandom_range(99) < p_mrrdy);
    bus.m_wdata_ready = ($urandom_range(99) < p_mwrdy);
    bus.m_rdata_valid = (rsp_data.size() > 0) && (rsp_time[0] <= cyc);
    bus.m_rdata       = bus.m_rdata_valid ? rsp_data[0] : $urandom;
  endtask

  task automatic check_cycle();
    logic [1:0]  rq, wq, e_srr, e_srv, e_swr;
    bit          g, wg, full, empty, head, e_mv, e_mrr, wany;
    logic [31:0] e;
    rq    = {rd_pend[1], rd_pend[0]};
    full  = (idq.size() == OUT);
    empty = (idq.size() == 0);
    g     = (rq == 2'b11) ? rd_pri : rq[1];
    e_mv  = (rq != 2'b00) && !full;
    e_srr = 2'b00;
    if (e_mv && bus.m_raddr_ready) e_srr[g] = 1'b1;
    chk("m_raddr_valid", bus.m_raddr_valid, e_mv);
    chk("s_raddr_ready", bus.s_raddr_ready, e_srr);
    if (e_mv) chk("m_raddr", bus.m_raddr, rd_addr[g]);
    rd_hs = e_mv && bus.m_raddr_ready;
    rd_g  = g;

    head = 1'b0;
    if (!empty) head = idq[0];
    e_srv = 2'b00;
    if (!empty && bus.m_rdata_valid) e_srv[head] = 1'b1;
    e_mrr = !empty && bus.s_rdata_ready[head];
    chk("s_rdata_valid", bus.s_rdata_valid, e_srv);
    chk("m_rdata_ready", bus.m_rdata_ready, e_mrr);
    rsp_hs  = bus.m_rdata_valid && e_mrr;
    rsp_id  = head;
    rsp_val = bus.s_rdata;
    if (rsp_hs) begin
      chk("s_rdata", bus.s_rdata, rsp_data[0]);
      if (head) e = exp1.pop_front();
      else      e = exp0.pop_front();
      chk(head ? "rdata_m1" : "rdata_m0", bus.s_rdata, e);
    end

    wq    = bus.s_wen & bus.s_wdata_valid;
    wany  = (wq != 2'b00);
    wg    = (wq == 2'b11) ? wr_pri : wq[1];
    e_swr = 2'b00;
    if (wany && bus.m_wdata_ready) e_swr[wg] = 1'b1;
    chk("m_wen", bus.m_wen, wany);
    chk("m_wdata_valid", bus.m_wdata_valid, wany);
    chk("s_wdata_ready", bus.s_wdata_ready, e_swr);
    if (wany) begin
      chk("m_waddr", bus.m_waddr, wr_addr[wg]);
      chk("m_wdata", bus.m_wdata, wr_dat[wg]);
    end
    wr_hs = wany && bus.m_wdata_ready;
    wr_g  = wg;

    obs_srr   = bus.s_raddr_ready;
    obs_srv   = bus.s_rdata_valid;
    obs_swr   = bus.s_wdata_ready;
    obs_maddr = bus.m_raddr;
    obs_rdata = bus.s_rdata;
    obs_waddr = bus.m_waddr;
  endtask

  task automatic update();
    logic [31:0] d;
    if (rsp_hs) begin
      void'(idq.pop_front());
      void'(rsp_data.pop_front());
      void'(rsp_time.pop_front());
    end
    // Memory samples read data before a same-cycle write lands.
    if (rd_hs) begin
      d = mem_rd(rd_addr[rd_g]);
      idq.push_back(rd_g);
      if (rd_g) exp1.push_back(d);
      else      exp0.push_back(d);
      rsp_data.push_back(d);
      rsp_time.push_back(cyc + 1 + longint'($urandom_range(lat_max)));
      rd_pend[rd_g] = 1'b0;
      rd_pri        = !rd_g;
    end
    if (wr_hs) begin
      mem[wr_addr[wr_g]] = wr_dat[wr_g];
      wr_pend[wr_g]      = 1'b0;
      wr_pri             = !wr_g;
    end
    cyc++;
  endtask

  task automatic step();
    drive();
    @(negedge i_clk);
    check_cycle();
    @(posedge i_clk);
    update();
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_s_raddr_ready"}, bus.s_raddr_ready, 2'b00);
    chk({tag, "_s_rdata_valid"}, bus.s_rdata_valid, 2'b00);
    chk({tag, "_s_wdata_ready"}, bus.s_wdata_ready, 2'b00);
    chk({tag, "_m_raddr_valid"}, bus.m_raddr_valid, 1'b0);
    chk({tag, "_m_rdata_ready"}, bus.m_rdata_ready, 1'b0);
    chk({tag, "_m_wen"},         bus.m_wen,         1'b0);
    chk({tag, "_m_wdata_valid"}, bus.m_wdata_valid, 1'b0);
  endtask

  // Reset asserted mid-cycle with live requests; outputs must drop at once.
  task automatic async_reset(input string tag);
    drive();
    #2;
    i_rst_n = 1'b0;
    #1;
    check_quiet({tag, "_async"});
    idq.delete(); exp0.delete(); exp1.delete();
    rsp_data.delete(); rsp_time.delete();
    rd_pri = 1'b0;
    wr_pri = 1'b0;
    @(posedge i_clk);
    #1;
    check_quiet({tag, "_held"});
    for (int m = 0; m < 2; m++) begin
      rd_pend[m] = 1'b0;
      wr_pend[m] = 1'b0;
    end
    bus.s_raddr_valid = '0;
    bus.s_wen         = '0;
    bus.s_wdata_valid = '0;
    bus.m_rdata_valid = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic read_one(input int m, input logic [31:0] a, input logic [31:0] e,
                          input string tag);
    bit done = 1'b0;
    rd_pend[m] = 1'b1;
    rd_addr[m] = a;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      if (rsp_hs && rsp_id == m[0]) begin
        chk(tag, rsp_val, e);
        done = 1'b1;
      end
    end
    chk({tag, "_timeout"}, done, 1'b1);
  endtask

  task automatic set_knobs(input int unsigned rd0, input int unsigned rd1, input int unsigned wr,
                           input int unsigned rrdy, input int unsigned mrrdy,
                           input int unsigned mwrdy, input int unsigned lat);
    p_rd[0] = rd0; p_rd[1] = rd1; p_wr = wr;
    p_rrdy = rrdy; p_mrrdy = mrrdy; p_mwrdy = mwrdy; lat_max = lat;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with every input active
    set_knobs(100, 100, 100, 100, 100, 100, 0);
    async_reset("rst");

    // Simultaneous writes: master0 first, then master1
    set_knobs(0, 0, 0, 100, 100, 100, 0);
    wr_pend[0] = 1'b1; wr_addr[0] = 32'h20; wr_dat[0] = 32'h1111_2020;
    wr_pend[1] = 1'b1; wr_addr[1] = 32'h24; wr_dat[1] = 32'h2222_2424;
    step();
    chk("wr_first_addr",  obs_waddr, 32'h20);
    chk("wr_first_ready", obs_swr,   2'b01);
    step();
    chk("wr_second_addr",  obs_waddr, 32'h24);
    chk("wr_second_ready", obs_swr,   2'b10);

    // Lone read by master0, one-cycle memory response
    mem[32'h10] = 32'hA5;
    rd_pend[0] = 1'b1; rd_addr[0] = 32'h10;
    step();
    chk("rd0_m_raddr", obs_maddr, 32'h10);
    chk("rd0_accept",  obs_srr,   2'b01);
    step();
    chk("rd0_rvalid", obs_srv,   2'b01);
    chk("rd0_rdata",  obs_rdata, 32'hA5);

    // Readback of the writes
    read_one(1, 32'h20, 32'h1111_2020, "rb_20");
    read_one(0, 32'h24, 32'h2222_2424, "rb_24");

    // Responses blocked: four reads fill the FIFO, the fifth stalls
    set_knobs(100, 100, 0, 0, 100, 100, 0);
    repeat (8) step();
    chk("full_no_issue", bus.m_raddr_valid, 1'b0);
    chk("full_no_ready", obs_srr, 2'b00);
    // Pop while full: no push that cycle, push on the next
    p_rrdy = 100;
    step();
    chk("full_pop", rsp_hs, 1'b1);
    chk("full_pop_no_push", obs_srr, 2'b00);
    p_rrdy = 0;
    step();
    chk("refill_push", (obs_srr != 2'b00), 1'b1);
    step();
    chk("refull_block", obs_srr, 2'b00);

    // Drain, then leave three reads outstanding from master0 and reset
    set_knobs(0, 0, 0, 100, 100, 100, 0);
    repeat (12) step();
    set_knobs(100, 0, 0, 0, 100, 100, 0);
    repeat (3) step();
    async_reset("midrst");

    // Both masters read every cycle: grants alternate starting with master0
    set_knobs(100, 100, 0, 100, 100, 100, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("alt_grant", obs_srr, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    set_knobs(0, 0, 0, 100, 100, 100, 0);
    repeat (6) step();

    // Randomized traffic
    for (int ph = 0; ph < 5; ph++) begin
      set_knobs($urandom_range(100, 20), $urandom_range(100, 20), $urandom_range(80),
                $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30),
                $urandom_range(3));
      repeat (400) step();
      if (ph == 2) async_reset("rndrst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
